// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the line-granular data memory responder.
// Holds the FSM state encoding and the line geometry helpers.
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int LINE_BYTES  = 32;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_line_ram.sv
// Single-port line store: synchronous write, registered read.
// Only the read register is reset; stored lines survive reset.
module dmem_line_ram #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 512,
    parameter int IDX_W      = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      index,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (en && we) begin
            mem[index] <= wdata;
        end
    end

    // Read data holds its last value until the next read, writes leave it alone
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder side of the cache-to-memory line handshake with fixed access latency.
// Optional request-stability checker enabled by defining DATA_MEMORY_PROTO_CHECK_EN.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_enable_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_ack_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    localparam int IDX_W = index_width(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state;
    state_t                next_state;
    logic [CNT_W-1:0]      counter;
    logic [IDX_W-1:0]      req_index;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  ram_en;
    logic [IDX_W-1:0]      addr_index;

    assign addr_index = mem_addr_i[OFFSET_BITS +: IDX_W];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request is captured once at acceptance; the counter runs down to the commit edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            counter   <= '0;
            req_index <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
        end else if (state == IDLE && mem_enable_i) begin
            counter   <= CNT_W'(LATENCY - 1);
            req_index <= addr_index;
            req_write <= mem_write_i;
            req_data  <= mem_data_i;
        end else if (state == BUSY && mem_enable_i && counter != '0) begin
            counter <= counter - 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (mem_enable_i) next_state = BUSY;
            BUSY: begin
                if (!mem_enable_i) begin
                    next_state = IDLE;
                end else if (counter == '0) begin
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_ack_o = 1'b0;
        busy_o    = 1'b0;
        ram_en    = 1'b0;
        if (state == ACK) mem_ack_o = 1'b1;
        if (state != IDLE) busy_o = 1'b1;
        if (state == BUSY && mem_enable_i && counter == '0) ram_en = 1'b1;
    end

    dmem_line_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en   (ram_en),
        .we   (req_write),
        .index(req_index),
        .wdata(req_data),
        .rdata(mem_data_o)
    );

`ifdef DATA_MEMORY_PROTO_CHECK_EN
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  proto_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_addr <= '0;
        end else if (state == IDLE && mem_enable_i) begin
            req_addr <= mem_addr_i;
        end
    end

    // Any change to a held request, including abandoning it, is sticky until reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            proto_err <= 1'b0;
        end else if (state == BUSY &&
                     (!mem_enable_i ||
                      mem_addr_i != req_addr ||
                      mem_write_i != req_write ||
                      (req_write && mem_data_i != req_data))) begin
            proto_err <= 1'b1;
        end
    end

    assign proto_err_o = proto_err;
`else
    logic addr_unused;
    assign addr_unused = ^mem_addr_i;
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (LATENCY=10 and LATENCY=1 instances).
module tb_data_memory_responder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en0;
    logic         en1;
    logic         mem_write_i;
    logic [31:0]  mem_addr_i;
    logic [255:0] mem_data_i;
    logic         ack0, ack1;
    logic [255:0] data0, data1;
    logic         busy0, busy1;
    logic         perr0, perr1;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] PAT_P  = {8{32'h0123_4567}};
    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_Q  = {8{32'hC0FF_EE00}};
    localparam logic [255:0] PAT_Z  = {8{32'h5A5A_0F0F}};
    localparam logic [255:0] PAT_W  = {8{32'h7777_1111}};
    localparam logic [255:0] PAT_P1 = {8{32'h0BAD_F00D}};

    always #5 clk_i = ~clk_i;

    data_memory_responder #(.DATA_WIDTH(256), .ADDR_WIDTH(32), .DEPTH(512), .LATENCY(10)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_enable_i(en0),
        .mem_write_i (mem_write_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_ack_o   (ack0),
        .mem_data_o  (data0),
        .busy_o      (busy0),
        .proto_err_o (perr0)
    );

    data_memory_responder #(.DATA_WIDTH(256), .ADDR_WIDTH(32), .DEPTH(512), .LATENCY(1)) dut1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_enable_i(en1),
        .mem_write_i (mem_write_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_ack_o   (ack1),
        .mem_data_o  (data1),
        .busy_o      (busy1),
        .proto_err_o (perr1)
    );

    // Drives one request, holding enable until ack; k counts cycles after the sampling edge
    task automatic run_req(input bit sel, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wd, output int ack_k, output int ack_cnt,
                           output int busy_cnt, output logic [255:0] rd);
        logic a, b;
        @(posedge clk_i); #1;
        mem_write_i = wr;
        mem_addr_i  = addr;
        mem_data_i  = wd;
        if (sel) en1 = 1'b1; else en0 = 1'b1;
        ack_k = -1; ack_cnt = 0; busy_cnt = 0; rd = '0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            a = sel ? ack1 : ack0;
            b = sel ? busy1 : busy0;
            if (b) busy_cnt++;
            if (a) begin
                ack_cnt++;
                if (ack_k < 0) begin
                    ack_k = k;
                    rd = sel ? data1 : data0;
                end
                en0 = 1'b0;
                en1 = 1'b0;
            end
        end
        en0 = 1'b0;
        en1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; en0 = 1'b0; en1 = 1'b0;
        mem_write_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (ack0 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ack got %b want 0", ack0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy0); end
        checks++; if (data0 !== '0)   begin errors++; $display("[TB] FAIL reset_data got %h want 0", data0); end
        checks++; if (perr0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr got %b want 0", perr0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy1 got %b want 0", busy1); end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
    endtask

    task automatic test_read_latency();
        int k, n, b;
        logic [255:0] rd;
        run_req(1'b0, 1'b1, 32'h0000_0420, PAT_P, k, n, b, rd);
        checks++; if (k !== 10) begin errors++; $display("[TB] FAIL preload_ack_cycle got %0d want 10", k); end
        run_req(1'b0, 1'b0, 32'h0000_0420, '0, k, n, b, rd);
        checks++; if (k !== 10)    begin errors++; $display("[TB] FAIL read_ack_cycle got %0d want 10", k); end
        checks++; if (n !== 1)     begin errors++; $display("[TB] FAIL read_ack_count got %0d want 1", n); end
        checks++; if (b !== 11)    begin errors++; $display("[TB] FAIL read_busy_cycles got %0d want 11", b); end
        checks++; if (rd !== PAT_P) begin errors++; $display("[TB] FAIL read_data got %h want %h", rd, PAT_P); end
    endtask

    task automatic test_read_after_write();
        int k, n, b;
        logic [255:0] rd;
        run_req(1'b0, 1'b1, 32'h0000_0420, PAT_A5, k, n, b, rd);
        checks++; if (n !== 1)     begin errors++; $display("[TB] FAIL raw_write_ack_count got %0d want 1", n); end
        checks++; if (rd !== PAT_P) begin errors++; $display("[TB] FAIL raw_data_held got %h want %h", rd, PAT_P); end
        run_req(1'b0, 1'b0, 32'h0000_0420, '0, k, n, b, rd);
        checks++; if (rd !== PAT_A5) begin errors++; $display("[TB] FAIL raw_read_data got %h want %h", rd, PAT_A5); end
    endtask

    task automatic test_back_to_back();
        int k1, k2, n, k, b;
        logic [255:0] rd;
        k1 = -1; k2 = -1; n = 0; rd = '0;
        @(posedge clk_i); #1;
        mem_write_i = 1'b1; mem_addr_i = 32'h0000_8000; mem_data_i = PAT_Q; en0 = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (ack0) begin
                n++;
                if (k1 < 0) begin
                    k1 = i;
                    mem_write_i = 1'b0;
                end else if (k2 < 0) begin
                    k2 = i;
                    rd = data0;
                    en0 = 1'b0;
                end
            end
        end
        en0 = 1'b0;
        checks++; if (k2 - k1 !== 12) begin errors++; $display("[TB] FAIL b2b_gap got %0d want 12", k2 - k1); end
        checks++; if (n !== 2)        begin errors++; $display("[TB] FAIL b2b_ack_count got %0d want 2", n); end
        checks++; if (rd !== PAT_Q)   begin errors++; $display("[TB] FAIL b2b_read_data got %h want %h", rd, PAT_Q); end
        run_req(1'b0, 1'b0, 32'h0000_0000, '0, k, n, b, rd);
        checks++; if (rd !== PAT_Q)   begin errors++; $display("[TB] FAIL alias_line0 got %h want %h", rd, PAT_Q); end
    endtask

    task automatic test_abandon();
        int n, k, b;
        logic [255:0] rd;
        n = 0;
        @(posedge clk_i); #1;
        mem_write_i = 1'b1; mem_addr_i = 32'h0000_0420; mem_data_i = PAT_Z; en0 = 1'b1;
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (ack0) n++;
        end
        en0 = 1'b0;
        repeat (14) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (ack0) n++;
        end
        checks++; if (n !== 0)        begin errors++; $display("[TB] FAIL abandon_ack_count got %0d want 0", n); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL abandon_idle got %b want 0", busy0); end
`ifdef DATA_MEMORY_PROTO_CHECK_EN
        checks++; if (perr0 !== 1'b1) begin errors++; $display("[TB] FAIL abandon_perr got %b want 1", perr0); end
`else
        checks++; if (perr0 !== 1'b0) begin errors++; $display("[TB] FAIL abandon_perr got %b want 0", perr0); end
`endif
        run_req(1'b0, 1'b0, 32'h0000_0420, '0, k, n, b, rd);
        checks++; if (rd !== PAT_A5)  begin errors++; $display("[TB] FAIL abandon_line_kept got %h want %h", rd, PAT_A5); end
`ifdef DATA_MEMORY_PROTO_CHECK_EN
        checks++; if (perr0 !== 1'b1) begin errors++; $display("[TB] FAIL perr_sticky got %b want 1", perr0); end
`endif
    endtask

    task automatic test_reset_mid();
        int k, n, b;
        logic [255:0] rd;
        @(posedge clk_i); #1;
        mem_write_i = 1'b1; mem_addr_i = 32'h0000_0420; mem_data_i = PAT_W; en0 = 1'b1;
        repeat (4) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
        rst_i = 1'b0;
        #1;
        checks++; if (ack0 !== 1'b0)  begin errors++; $display("[TB] FAIL midreset_ack got %b want 0", ack0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy0); end
        checks++; if (data0 !== '0)   begin errors++; $display("[TB] FAIL midreset_data got %h want 0", data0); end
        en0 = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        checks++; if (perr0 !== 1'b0) begin errors++; $display("[TB] FAIL midreset_perr got %b want 0", perr0); end
        run_req(1'b0, 1'b0, 32'h0000_0420, '0, k, n, b, rd);
        checks++; if (rd !== PAT_A5) begin errors++; $display("[TB] FAIL midreset_line_kept got %h want %h", rd, PAT_A5); end
        run_req(1'b0, 1'b0, 32'h0000_8000, '0, k, n, b, rd);
        checks++; if (rd !== PAT_Q)  begin errors++; $display("[TB] FAIL midreset_retained got %h want %h", rd, PAT_Q); end
    endtask

    task automatic test_latency_one();
        int k, n, b;
        int acks [3];
        logic [255:0] rd;
        logic [255:0] rds [3];
        run_req(1'b1, 1'b1, 32'h0000_0420, PAT_P1, k, n, b, rd);
        checks++; if (k !== 1) begin errors++; $display("[TB] FAIL l1_write_ack_cycle got %0d want 1", k); end
        checks++; if (n !== 1) begin errors++; $display("[TB] FAIL l1_write_ack_count got %0d want 1", n); end
        n = 0;
        for (int i = 0; i < 3; i++) begin acks[i] = -1; rds[i] = '0; end
        @(posedge clk_i); #1;
        mem_write_i = 1'b0; mem_addr_i = 32'h0000_0420; en1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (ack1) begin
                if (n < 3) begin
                    acks[n] = i;
                    rds[n]  = data1;
                end
                n++;
                en1 = 1'b0;
            end
            if (i == 3 || i == 7) en1 = 1'b1;
        end
        en1 = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("[TB] FAIL l1_read_ack_count got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acks[i] !== 4 * i + 1) begin
                errors++; $display("[TB] FAIL l1_read_ack_cycle[%0d] got %0d want %0d", i, acks[i], 4 * i + 1);
            end
            checks++;
            if (rds[i] !== PAT_P1) begin
                errors++; $display("[TB] FAIL l1_read_data[%0d] got %h want %h", i, rds[i], PAT_P1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_read_after_write();
        test_back_to_back();
        test_abandon();
        test_reset_mid();
        test_latency_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
